// File: rtl/crc32_pkg.sv
// crc32_pkg
// Shared constants and helper functions for the streaming CRC-32 block.
//   CRC32_POLY / CRC32_INIT / CRC32_XOR_OUT : default CRC-32 (MSB-first) settings
//   crc32_byte  : advance a CRC register by one byte, MSB-first
//   nbytes_norm : map an out-of-range byte count onto a full beat
package crc32_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_XOR_OUT = 32'hFFFF_FFFF;

    // One byte of the non-reflected CRC recurrence, bit 7 of the byte first.
    function automatic logic [31:0] crc32_byte(
        input logic [31:0] crc,
        input logic [7:0]  data_byte,
        input logic [31:0] poly
    );
        logic [31:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[31] ^ data_byte[i]) begin
                c = {c[30:0], 1'b0} ^ poly;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

    // A count of 0 or one larger than the beat means "whole beat".
    function automatic int unsigned nbytes_norm(
        input int unsigned n,
        input int unsigned data_bytes
    );
        if ((n == 32'd0) || (n > data_bytes)) begin
            return data_bytes;
        end else begin
            return n;
        end
    endfunction

endpackage

// File: rtl/crc32_beat_update.sv
// crc32_beat_update
// Purely combinational: folds the first n bytes of one beat into a CRC value.
//   crc_in  : CRC register before this beat
//   data    : beat data, first-transmitted byte in the top byte lane
//   n       : bytes to fold, 1..DATA_BYTES (any other value folds the whole beat)
//   crc_out : CRC register after folding n bytes
module crc32_beat_update
    import crc32_pkg::*;
#(
    parameter int          DATA_BYTES = 8,
    parameter logic [31:0] POLY       = CRC32_POLY,
    parameter int          NB_W       = $clog2(DATA_BYTES) + 1
) (
    input  logic [31:0]             crc_in,
    input  logic [8*DATA_BYTES-1:0] data,
    input  logic [NB_W-1:0]         n,
    output logic [31:0]             crc_out
);

    // Each step owns its own tap so the chain is a plain ripple of byte updates.
    // pick_s carries the tap selected by n forward; hit_s records that a match
    // happened so the chain end can fall back to the full-beat tap otherwise.
    for (genvar k = 0; k < DATA_BYTES; k++) begin : gen_step
        logic [31:0] prev_tap_s;
        logic [31:0] prev_pick_s;
        logic        prev_hit_s;
        logic [31:0] tap_s;
        logic [31:0] pick_s;
        logic        hit_s;

        if (k == 0) begin : g_first
            assign prev_tap_s  = crc_in;
            assign prev_pick_s = crc_in;
            assign prev_hit_s  = 1'b0;
        end else begin : g_next
            assign prev_tap_s  = gen_step[k-1].tap_s;
            assign prev_pick_s = gen_step[k-1].pick_s;
            assign prev_hit_s  = gen_step[k-1].hit_s;
        end

        assign tap_s  = crc32_byte(prev_tap_s, data[8*(DATA_BYTES-k)-1 -: 8], POLY);
        assign pick_s = (n == NB_W'(k + 1)) ? tap_s : prev_pick_s;
        assign hit_s  = prev_hit_s | (n == NB_W'(k + 1));
    end

    assign crc_out = gen_step[DATA_BYTES-1].hit_s ? gen_step[DATA_BYTES-1].pick_s
                                                  : gen_step[DATA_BYTES-1].tap_s;

endmodule

// File: rtl/crc32_stream.sv
// crc32_stream
// Inline streaming CRC-32: beats pass through a 3-stage delay line while a
// running CRC is accumulated and presented alongside each output beat.
//   clk, rst (sync, active high), ce (global clock enable, rst wins)
//   valid_in/init_in/last_in/nbytes_in/data_in : input beat and framing
//   valid_out/init_out/last_out/nbytes_out/data_out : same beat, 3 ce cycles later
//   crc       : running CRC ^ XOR_OUT through the output beat
//   crc_valid : valid_out & last_out, crc is the frame's final CRC
module crc32_stream
    import crc32_pkg::*;
#(
    parameter int          DATA_BYTES = 8,
    parameter logic [31:0] POLY       = CRC32_POLY,
    parameter logic [31:0] INIT       = CRC32_INIT,
    parameter logic [31:0] XOR_OUT    = CRC32_XOR_OUT,
    parameter int          NB_W       = $clog2(DATA_BYTES) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic                    valid_in,
    input  logic                    init_in,
    input  logic                    last_in,
    input  logic [NB_W-1:0]         nbytes_in,
    input  logic [8*DATA_BYTES-1:0] data_in,
    output logic                    valid_out,
    output logic                    init_out,
    output logic                    last_out,
    output logic [NB_W-1:0]         nbytes_out,
    output logic [8*DATA_BYTES-1:0] data_out,
    output logic [31:0]             crc,
    output logic                    crc_valid
);

    localparam int DW = 8 * DATA_BYTES;

    // Stage 0: registered inputs
    logic            s0_valid_q, s0_valid_d;
    logic            s0_init_q,  s0_init_d;
    logic            s0_last_q,  s0_last_d;
    logic [NB_W-1:0] s0_nbytes_q, s0_nbytes_d;
    logic [DW-1:0]   s0_data_q,  s0_data_d;
    // Stage 1: delay line alongside the accumulator
    logic            s1_valid_q, s1_valid_d;
    logic            s1_init_q,  s1_init_d;
    logic            s1_last_q,  s1_last_d;
    logic [NB_W-1:0] s1_nbytes_q, s1_nbytes_d;
    logic [DW-1:0]   s1_data_q,  s1_data_d;
    logic [31:0]     acc_q,      acc_d;
    // Stage 2: output registers
    logic            out_valid_q, out_valid_d;
    logic            out_init_q,  out_init_d;
    logic            out_last_q,  out_last_d;
    logic [NB_W-1:0] out_nbytes_q, out_nbytes_d;
    logic [DW-1:0]   out_data_q,  out_data_d;
    logic [31:0]     out_crc_q,   out_crc_d;
    logic            out_crc_valid_q, out_crc_valid_d;

    logic [31:0]     base_s;
    logic [NB_W-1:0] fold_n_s;
    logic [31:0]     beat_crc_s;

    crc32_beat_update #(
        .DATA_BYTES (DATA_BYTES),
        .POLY       (POLY),
        .NB_W       (NB_W)
    ) u_beat (
        .crc_in  (base_s),
        .data    (s0_data_q),
        .n       (fold_n_s),
        .crc_out (beat_crc_s)
    );

    // Next-state for the delay line, accumulator and output stage.
    always_comb begin
        s0_valid_d  = valid_in;
        s0_init_d   = init_in;
        s0_last_d   = last_in;
        s0_nbytes_d = NB_W'(nbytes_norm(32'(nbytes_in), DATA_BYTES));
        s0_data_d   = data_in;

        s1_valid_d  = s0_valid_q;
        s1_init_d   = s0_init_q;
        s1_last_d   = s0_last_q;
        s1_nbytes_d = s0_nbytes_q;
        s1_data_d   = s0_data_q;

        // A new frame restarts from INIT even if the previous one never ended.
        if (s0_init_q) begin
            base_s = INIT;
        end else begin
            base_s = acc_q;
        end

        // Only a last beat may be partial; nbytes is already normalised.
        if (s0_last_q) begin
            fold_n_s = s0_nbytes_q;
        end else begin
            fold_n_s = NB_W'(DATA_BYTES);
        end

        if (s0_valid_q) begin
            acc_d = beat_crc_s;
        end else begin
            acc_d = acc_q;
        end

        out_valid_d     = s1_valid_q;
        out_init_d      = s1_init_q;
        out_last_d      = s1_last_q;
        out_nbytes_d    = s1_nbytes_q;
        out_data_d      = s1_data_q;
        // acc_q already includes the beat now sitting in stage 1.
        out_crc_d       = acc_q ^ XOR_OUT;
        out_crc_valid_d = s1_valid_q & s1_last_q;
    end

    // Pipeline registers: reset beats ce, ce=0 freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q      <= 1'b0;
            s0_init_q       <= 1'b0;
            s0_last_q       <= 1'b0;
            s0_nbytes_q     <= '0;
            s0_data_q       <= '0;
            s1_valid_q      <= 1'b0;
            s1_init_q       <= 1'b0;
            s1_last_q       <= 1'b0;
            s1_nbytes_q     <= '0;
            s1_data_q       <= '0;
            acc_q           <= INIT;
            out_valid_q     <= 1'b0;
            out_init_q      <= 1'b0;
            out_last_q      <= 1'b0;
            out_nbytes_q    <= '0;
            out_data_q      <= '0;
            out_crc_q       <= 32'h0000_0000;
            out_crc_valid_q <= 1'b0;
        end else if (ce) begin
            s0_valid_q      <= s0_valid_d;
            s0_init_q       <= s0_init_d;
            s0_last_q       <= s0_last_d;
            s0_nbytes_q     <= s0_nbytes_d;
            s0_data_q       <= s0_data_d;
            s1_valid_q      <= s1_valid_d;
            s1_init_q       <= s1_init_d;
            s1_last_q       <= s1_last_d;
            s1_nbytes_q     <= s1_nbytes_d;
            s1_data_q       <= s1_data_d;
            acc_q           <= acc_d;
            out_valid_q     <= out_valid_d;
            out_init_q      <= out_init_d;
            out_last_q      <= out_last_d;
            out_nbytes_q    <= out_nbytes_d;
            out_data_q      <= out_data_d;
            out_crc_q       <= out_crc_d;
            out_crc_valid_q <= out_crc_valid_d;
        end
    end

    assign valid_out  = out_valid_q;
    assign init_out   = out_init_q;
    assign last_out   = out_last_q;
    assign nbytes_out = out_nbytes_q;
    assign data_out   = out_data_q;
    assign crc        = out_crc_q;
    assign crc_valid  = out_crc_valid_q;

endmodule
